// File: rtl/geo_point_sink.sv
// Point sink for the geometry engine: FWFT point FIFO plus per-burst summary.
// Optional burst checksum enabled by defining GEO_SINK_CHECKSUM_EN.
module geo_point_sink #(
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic [7:0]                 in_x,
   input  logic [7:0]                 in_y,
   output logic                       pt_valid,
   input  logic                       pt_ready,
   output logic [7:0]                 pt_x,
   output logic [7:0]                 pt_y,
   output logic [$clog2(DEPTH):0]     fifo_level,
   output logic                       frame_done,
   output logic [15:0]                frame_cnt,
   output logic [7:0]                 min_x,
   output logic [7:0]                 min_y,
   output logic [7:0]                 max_x,
   output logic [7:0]                 max_y,
   output logic                       frame_ovf,
   output logic [15:0]                checksum
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic [1:0] {
      IDLE,
      BURST,
      REPORT
   } state_t;

   state_t          state;
   logic [15:0]     mem [DEPTH];
   logic [AW-1:0]   wptr;
   logic [AW-1:0]   rptr;
   logic [LW-1:0]   level;
   logic [15:0]     head;
   logic            full;
   logic            pop;
   logic            wr;
   logic            drop;

   assign full     = (level == LW'(DEPTH));
   assign pt_valid = (level != '0);
   assign pop      = pt_valid && pt_ready;
   // A full FIFO still accepts a point when the head leaves in the same cycle
   assign wr       = in_valid && (!full || pop);
   assign drop     = in_valid && full && !pop;

   assign head       = mem[rptr];
   assign pt_x       = pt_valid ? head[15:8] : 8'h00;
   assign pt_y       = pt_valid ? head[7:0]  : 8'h00;
   assign fifo_level = level;

   always_ff @(posedge clk) begin
      if (wr) mem[wptr] <= {in_x, in_y};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
      end else begin
         if (wr)  wptr <= wptr + AW'(1);
         if (pop) rptr <= rptr + AW'(1);
         unique case ({wr, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         frame_done <= 1'b0;
         frame_cnt  <= 16'h0000;
         min_x      <= 8'hFF;
         min_y      <= 8'hFF;
         max_x      <= 8'h00;
         max_y      <= 8'h00;
         frame_ovf  <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         unique case (state)
            IDLE, REPORT: begin
               if (in_valid) begin
                  state     <= BURST;
                  frame_cnt <= 16'h0001;
                  min_x     <= in_x;
                  min_y     <= in_y;
                  max_x     <= in_x;
                  max_y     <= in_y;
                  frame_ovf <= drop;
               end else begin
                  state <= IDLE;
               end
            end
            BURST: begin
               if (in_valid) begin
                  if (frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 16'h0001;
                  if (in_x < min_x) min_x <= in_x;
                  if (in_y < min_y) min_y <= in_y;
                  if (in_x > max_x) max_x <= in_x;
                  if (in_y > max_y) max_y <= in_y;
                  if (drop) frame_ovf <= 1'b1;
               end else begin
                  state      <= REPORT;
                  frame_done <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef GEO_SINK_CHECKSUM_EN
   logic [15:0] ck;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ck <= 16'h0000;
      end else if (in_valid) begin
         ck <= (state == BURST) ? ck + {in_x, in_y} : {in_x, in_y};
      end
   end

   assign checksum = ck;
`else
   assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_geo_point_sink.sv
// Directed bench for geo_point_sink with a point scoreboard and summary model.
module tb_geo_point_sink;

   localparam int DEPTH = 16;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [7:0]  in_x;
   logic [7:0]  in_y;
   logic        pt_valid;
   logic        pt_ready;
   logic [7:0]  pt_x;
   logic [7:0]  pt_y;
   logic [4:0]  fifo_level;
   logic        frame_done;
   logic [15:0] frame_cnt;
   logic [7:0]  min_x;
   logic [7:0]  min_y;
   logic [7:0]  max_x;
   logic [7:0]  max_y;
   logic        frame_ovf;
   logic [15:0] checksum;

   int checks = 0;
   int errors = 0;

   logic [15:0] q[$];
   bit          m_burst;
   bit          m_done;
   logic [15:0] m_cnt;
   logic [7:0]  m_minx;
   logic [7:0]  m_miny;
   logic [7:0]  m_maxx;
   logic [7:0]  m_maxy;
   bit          m_ovf;
   logic [15:0] m_ck;

   geo_point_sink #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_x       (in_x),
      .in_y       (in_y),
      .pt_valid   (pt_valid),
      .pt_ready   (pt_ready),
      .pt_x       (pt_x),
      .pt_y       (pt_y),
      .fifo_level (fifo_level),
      .frame_done (frame_done),
      .frame_cnt  (frame_cnt),
      .min_x      (min_x),
      .min_y      (min_y),
      .max_x      (max_x),
      .max_y      (max_y),
      .frame_ovf  (frame_ovf),
      .checksum   (checksum)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_burst = 0;
      m_done  = 0;
      m_cnt   = 16'h0000;
      m_minx  = 8'hFF;
      m_miny  = 8'hFF;
      m_maxx  = 8'h00;
      m_maxy  = 8'h00;
      m_ovf   = 0;
      m_ck    = 16'h0000;
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_pt_valid"}, pt_valid, 0);
      chk({tag, "_pt_x"}, pt_x, 0);
      chk({tag, "_pt_y"}, pt_y, 0);
      chk({tag, "_level"}, fifo_level, 0);
      chk({tag, "_done"}, frame_done, 0);
      chk({tag, "_cnt"}, frame_cnt, 0);
      chk({tag, "_min"}, {min_x, min_y}, 16'hFFFF);
      chk({tag, "_max"}, {max_x, max_y}, 16'h0000);
      chk({tag, "_ovf"}, frame_ovf, 0);
      chk({tag, "_ck"}, checksum, 0);
   endtask

   task automatic check_state();
      logic [15:0] hd;
      hd = (q.size() != 0) ? q[0] : 16'h0000;
      chk("pt_valid", pt_valid, q.size() != 0);
      chk("level", fifo_level, q.size());
      chk("head", {pt_x, pt_y}, hd);
      chk("frame_done", frame_done, m_done);
      chk("frame_cnt", frame_cnt, m_cnt);
      chk("bbox", {min_x, min_y, max_x, max_y}, {m_minx, m_miny, m_maxx, m_maxy});
      chk("frame_ovf", frame_ovf, m_ovf);
`ifdef GEO_SINK_CHECKSUM_EN
      chk("checksum", checksum, m_ck);
`else
      chk("checksum", checksum, 16'h0000);
`endif
   endtask

   task automatic step(input bit v, input logic [7:0] x, input logic [7:0] y,
                       input bit rdy);
      bit pop;
      bit full;
      bit acc;
      bit drop;
      in_valid = v;
      in_x     = x;
      in_y     = y;
      pt_ready = rdy;
      pop  = (q.size() != 0) && rdy;
      full = (q.size() == DEPTH);
      acc  = v && (!full || pop);
      drop = v && full && !pop;
      @(posedge clk);
      #1;
      if (pop) void'(q.pop_front());
      if (acc) q.push_back({x, y});
      m_done = m_burst && !v;
      if (v) begin
         if (!m_burst) begin
            m_cnt  = 16'h0001;
            m_minx = x;
            m_miny = y;
            m_maxx = x;
            m_maxy = y;
            m_ovf  = drop;
            m_ck   = {x, y};
         end else begin
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'h0001;
            if (x < m_minx) m_minx = x;
            if (y < m_miny) m_miny = y;
            if (x > m_maxx) m_maxx = x;
            if (y > m_maxy) m_maxy = y;
            m_ovf = m_ovf | drop;
            m_ck  = m_ck + {x, y};
         end
      end
      m_burst = v;
      check_state();
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_x     = 8'h00;
      in_y     = 8'h00;
      pt_ready = 1'b0;
      model_reset();
      #12;
      check_reset_values("reset");
      @(negedge clk);
      rst = 1'b0;
      step(0, 0, 0, 0);

      // Four-point burst with a consumer always ready
      step(1, 8'd10, 8'd20, 1);
      chk("lat1_head", {pt_valid, pt_x, pt_y}, {1'b1, 8'd10, 8'd20});
      step(1, 8'd30, 8'd5, 1);
      step(1, 8'd0, 8'd255, 1);
      step(1, 8'd7, 8'd7, 1);
      step(0, 0, 0, 1);
      chk("b4_done", frame_done, 1);
      chk("b4_cnt", frame_cnt, 4);
      chk("b4_min", {min_x, min_y}, {8'd0, 8'd5});
      chk("b4_max", {max_x, max_y}, {8'd30, 8'd255});
      chk("b4_ovf", frame_ovf, 0);
      step(0, 0, 0, 1);
      chk("b4_done_clr", frame_done, 0);
      chk("b4_hold_cnt", frame_cnt, 4);
      step(0, 0, 0, 1);

      // Long burst into a stalled consumer overflows the FIFO
      for (int i = 0; i < 162; i++) step(1, 8'(i + 3), 8'(200 - i), 0);
      step(0, 0, 0, 0);
      chk("ovf_level", fifo_level, 16);
      chk("ovf_cnt", frame_cnt, 162);
      chk("ovf_flag", frame_ovf, 1);
      chk("ovf_head", {pt_x, pt_y}, {8'd3, 8'd200});
      step(0, 0, 0, 0);

      // Push and pop together while full
      step(1, 8'd90, 8'd91, 1);
      chk("full_pp_level", fifo_level, 16);
      step(1, 8'd92, 8'd93, 1);
      step(0, 0, 0, 0);
      chk("full_pp_level2", fifo_level, 16);
      chk("full_pp_ovf", frame_ovf, 0);
      chk("full_pp_cnt", frame_cnt, 2);

      // Drain: order is checked against the scoreboard every cycle
      for (int i = 0; i < 18; i++) step(0, 0, 0, 1);
      chk("drained", pt_valid, 0);
      step(0, 0, 0, 1);

      // Two bursts separated by a single idle cycle
      step(1, 8'd50, 8'd60, 0);
      step(1, 8'd40, 8'd70, 0);
      step(0, 0, 0, 0);
      chk("g1_done", frame_done, 1);
      chk("g1_cnt", frame_cnt, 2);
      step(1, 8'd100, 8'd1, 0);
      chk("g_gap_done", frame_done, 0);
      step(1, 8'd120, 8'd2, 1);
      step(0, 0, 0, 1);
      chk("g2_done", frame_done, 1);
      chk("g2_bbox", {min_x, min_y, max_x, max_y},
          {8'd100, 8'd1, 8'd120, 8'd2});
      chk("g2_cnt", frame_cnt, 2);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 1);

      // Reset in the middle of a burst
      for (int i = 0; i < 5; i++) step(1, 8'(i * 9), 8'(i * 5), 0);
      @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b0;
      #1;
      check_reset_values("async_rst");
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      step(0, 0, 0, 0);
      chk("rst_no_done", frame_done, 0);

      step(1, 8'd11, 8'd22, 1);
      step(1, 8'd33, 8'd44, 1);
      step(1, 8'd5, 8'd66, 1);
      step(0, 0, 0, 1);
      chk("post_rst_done", frame_done, 1);
      chk("post_rst_cnt", frame_cnt, 3);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
